// File: rtl/cb_fifo_if.sv
`default_nettype none
// ============================================================================
// Module : cb_fifo_if
// Brief  : Source/sink handshake and status bundle for cb_fifo.
// Rev    : 1.0  initial release
// ============================================================================
interface cb_fifo_if #(
   parameter int Data_W = 32,
   parameter int DEPTH  = 8
);
   localparam int c_LW = $clog2(DEPTH + 1);

   logic              s_valid;
   logic              s_ready;
   logic [Data_W-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [Data_W-1:0] m_data;
   logic [c_LW-1:0]   level;
   logic              empty;
   logic              full;
   logic [c_LW-1:0]   credits;

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, level, empty, full, credits
   );

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, level, empty, full, credits
   );
endinterface
`default_nettype wire

// File: rtl/cb_fifo.sv
`default_nettype none
// ============================================================================
// Module : cb_fifo
// Brief  : Circular-buffer FIFO, optional registered output and ready flop.
// Rev    : 1.0  initial release
// ============================================================================
module cb_fifo #(
   parameter int Data_W   = 32,
   parameter int DEPTH    = 8,
   parameter int PIPE_OUT = 0,
   parameter int SKID_EN  = 0
) (
   input  logic     clk,
   input  logic     rst_n,
   cb_fifo_if.slave bus
);
   localparam int              c_LW       = $clog2(DEPTH + 1);
   localparam int              c_PW       = $clog2(DEPTH);
   localparam logic [c_LW-1:0] c_DEPTH_L  = c_LW'(DEPTH);
   localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(DEPTH - 1);

   logic [Data_W-1:0] r_mem [DEPTH];
   logic [c_PW-1:0]   r_wptr;
   logic [c_PW-1:0]   r_rptr;
   logic [c_LW-1:0]   r_level;
   logic [c_LW-1:0]   w_level_nxt;
   logic              w_full;
   logic              w_empty;
   logic              w_s_ready;
   logic              w_m_valid;
   logic              w_push;
   logic              w_pop;
   logic              w_mem_we;
   logic              w_rd_adv;

   function automatic logic [c_PW-1:0] f_ptr_inc(input logic [c_PW-1:0] p);
      return (p == c_PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign w_full  = (r_level == c_DEPTH_L);
   assign w_empty = (r_level == '0);
   assign w_push  = bus.s_valid && w_s_ready;
   assign w_pop   = w_m_valid && bus.m_ready;

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop)
         w_level_nxt = r_level + 1'b1;
      else if (w_pop && !w_push)
         w_level_nxt = r_level - 1'b1;
   end

   if (SKID_EN != 0) begin : g_skid
      logic r_s_ready;
      always_ff @(posedge clk) begin
         if (rst_n)
            r_s_ready <= 1'b1;
         else
            r_s_ready <= (w_level_nxt < c_DEPTH_L);
      end
      assign w_s_ready = r_s_ready;
   end else begin : g_noskid
      assign w_s_ready = !w_full;
   end

   if (PIPE_OUT != 0) begin : g_pipe
      // The output register holds the head word, so storage is empty
      // whenever at most one word is in flight.
      logic              r_out_valid;
      logic [Data_W-1:0] r_out_data;
      logic              w_stor_empty;

      assign w_stor_empty = (r_level <= c_LW'(1));
      assign w_mem_we     = w_push && r_out_valid && !(w_pop && w_stor_empty);
      assign w_rd_adv     = w_pop && !w_stor_empty;

      always_ff @(posedge clk) begin
         if (rst_n) begin
            r_out_valid <= 1'b0;
         end else if (!r_out_valid || w_pop) begin
            if (!w_stor_empty) begin
               r_out_valid <= 1'b1;
               r_out_data  <= r_mem[r_rptr];
            end else if (w_push) begin
               r_out_valid <= 1'b1;
               r_out_data  <= bus.s_data;
            end else begin
               r_out_valid <= 1'b0;
            end
         end
      end

      assign w_m_valid  = r_out_valid;
      assign bus.m_data = r_out_data;
   end else begin : g_comb
      assign w_mem_we   = w_push;
      assign w_rd_adv   = w_pop;
      assign w_m_valid  = !w_empty;
      assign bus.m_data = r_mem[r_rptr];
   end

   always_ff @(posedge clk) begin
      if (!rst_n && w_mem_we)
         r_mem[r_wptr] <= bus.s_data;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_level <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else begin
         r_level <= w_level_nxt;
         if (w_mem_we)
            r_wptr <= f_ptr_inc(r_wptr);
         if (w_rd_adv)
            r_rptr <= f_ptr_inc(r_rptr);
      end
   end

   assign bus.s_ready = w_s_ready;
   assign bus.m_valid = w_m_valid;
   assign bus.level   = r_level;
   assign bus.empty   = w_empty;
   assign bus.full    = w_full;
   assign bus.credits = c_DEPTH_L - r_level;
endmodule
`default_nettype wire

// File: tb/tb_cb_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_cb_fifo
// Brief  : Directed and scoreboarded checks over all PIPE_OUT/SKID_EN builds.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cb_fifo;
   localparam int c_NDUT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic [31:0] s_data;
   logic        m_ready;

   logic [c_NDUT-1:0] w_sr, w_mv, w_emp, w_full;
   logic [31:0]       w_md  [c_NDUT];
   logic [3:0]        w_lvl [c_NDUT];
   logic [3:0]        w_cr  [c_NDUT];

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   // Index bit 0 selects PIPE_OUT, bit 1 selects SKID_EN.
   for (genvar g = 0; g < c_NDUT; g++) begin : g_dut
      cb_fifo_if #(.Data_W(32), .DEPTH(8)) u_if ();
      assign u_if.s_valid = s_valid;
      assign u_if.s_data  = s_data;
      assign u_if.m_ready = m_ready;
      cb_fifo #(.Data_W(32), .DEPTH(8), .PIPE_OUT(g % 2), .SKID_EN(g / 2)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (u_if.slave)
      );
      assign w_sr[g]  = u_if.s_ready;
      assign w_mv[g]  = u_if.m_valid;
      assign w_emp[g] = u_if.empty;
      assign w_full[g]= u_if.full;
      assign w_md[g]  = u_if.m_data;
      assign w_lvl[g] = u_if.level;
      assign w_cr[g]  = u_if.credits;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input int lvl);
      for (int k = 0; k < c_NDUT; k++) begin
         check($sformatf("%s.level[%0d]", tag, k),   32'(w_lvl[k]),  32'(lvl));
         check($sformatf("%s.credits[%0d]", tag, k), 32'(w_cr[k]),   32'(8 - lvl));
         check($sformatf("%s.empty[%0d]", tag, k),   32'(w_emp[k]),  32'(lvl == 0));
         check($sformatf("%s.full[%0d]", tag, k),    32'(w_full[k]), 32'(lvl == 8));
         check($sformatf("%s.s_ready[%0d]", tag, k), 32'(w_sr[k]),   32'(lvl < 8));
         check($sformatf("%s.m_valid[%0d]", tag, k), 32'(w_mv[k]),   32'(lvl > 0));
      end
   endtask

   task automatic check_data(input string tag, input logic [31:0] exp);
      for (int k = 0; k < c_NDUT; k++)
         check($sformatf("%s.m_data[%0d]", tag, k), w_md[k], exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] q [$];
      logic        do_push, do_pop;
      logic        hit_full, hit_empty, hit_pp, hit_bp;
      logic [8:0]  hit_lvl;
      int          pv;

      rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
      tick(); tick();
      rst_n = 1'b0;
      check_state("reset", 0);

      // Single word through an empty FIFO.
      s_valid = 1'b1; s_data = 32'hA5A5_0001;
      tick();
      s_valid = 1'b0;
      check_state("push1", 1);
      check_data("push1", 32'hA5A5_0001);
      m_ready = 1'b1;
      check_data("pop1", 32'hA5A5_0001);
      tick();
      m_ready = 1'b0;
      check_state("pop1", 0);

      // Fill to full, extra word ignored, drain in order.
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1; s_data = 32'hA5A5_0000 + 32'(i);
         tick();
      end
      check_state("full", 8);
      s_data = 32'hDEAD_BEEF;
      tick();
      s_valid = 1'b0;
      check_state("full_ign", 8);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check_data($sformatf("drain%0d", i), 32'hA5A5_0000 + 32'(i));
         tick();
      end
      m_ready = 1'b0;
      check_state("drained", 0);

      // Simultaneous push and pop at level 6, then mid-operation reset.
      for (int i = 0; i < 6; i++) begin
         s_valid = 1'b1; s_data = 32'hA5A5_1000 + 32'(i);
         tick();
      end
      s_data = 32'hA5A5_2000; m_ready = 1'b1;
      check_data("pp_pop", 32'hA5A5_1000);
      tick();
      s_valid = 1'b0; m_ready = 1'b0;
      check_state("pp", 6);
      check_data("pp_next", 32'hA5A5_1001);
      rst_n = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
      tick();
      rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      check_state("midrst", 0);

      s_valid = 1'b1; s_data = 32'h0000_0033;
      tick();
      s_valid = 1'b0;
      check_state("post_rst", 1);
      check_data("post_rst", 32'h0000_0033);

      rst_n = 1'b1;
      tick();
      rst_n = 1'b0;

      // Random traffic against a queue model; phases bias toward full/empty.
      hit_full = 0; hit_empty = 0; hit_pp = 0; hit_bp = 0; hit_lvl = '0;
      for (int i = 0; i < 1500; i++) begin
         pv = (i < 500) ? 75 : (i < 1000) ? 25 : 50;
         s_valid = ($urandom_range(0, 99) < pv);
         m_ready = ($urandom_range(0, 99) < (100 - pv));
         s_data  = $urandom;
         do_push = s_valid && (q.size() < 8);
         do_pop  = m_ready && (q.size() > 0);
         for (int k = 0; k < c_NDUT; k++) begin
            check($sformatf("rnd%0d.level[%0d]", i, k), 32'(w_lvl[k]), 32'(q.size()));
            check($sformatf("rnd%0d.s_ready[%0d]", i, k), 32'(w_sr[k]), 32'(q.size() < 8));
            check($sformatf("rnd%0d.m_valid[%0d]", i, k), 32'(w_mv[k]), 32'(q.size() > 0));
            if (do_pop)
               check($sformatf("rnd%0d.m_data[%0d]", i, k), w_md[k], q[0]);
         end
         if (q.size() == 8) hit_full = 1;
         if (q.size() == 0) hit_empty = 1;
         if (do_push && do_pop) hit_pp = 1;
         if (q.size() > 0 && !m_ready) hit_bp = 1;
         hit_lvl[q.size()] = 1'b1;
         tick();
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(s_data);
      end
      s_valid = 1'b0; m_ready = 1'b0;

      check("cov_full",   32'(hit_full),  32'd1);
      check("cov_empty",  32'(hit_empty), 32'd1);
      check("cov_pp",     32'(hit_pp),    32'd1);
      check("cov_bp",     32'(hit_bp),    32'd1);
      check("cov_levels", 32'(hit_lvl[7:1]), 32'h7F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/cb_fifo.md
CB_FIFO -- requirements
Module: cb_fifo

Interface
REQ-001 Parameter Data_W, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 8, storage capacity in words (>=2).
REQ-003 Parameter PIPE_OUT, default 0, 1 = m_valid/m_data driven directly from an output register.
REQ-004 Parameter SKID_EN, default 0, 1 = s_ready driven directly from a flop.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset is synchronous and active-high (rst_n=1 resets).
REQ-007 s_valid  input  1  source has a word on s_data.
REQ-008 s_ready  output  1  FIFO can accept a word this cycle.
REQ-009 s_data  input  Data_W  write data.
REQ-010 m_valid  output  1  m_data holds the oldest stored word.
REQ-011 m_ready  input  1  sink accepts m_data this cycle.
REQ-012 m_data  output  Data_W  oldest stored word.
REQ-013 level  output  $clog2(DEPTH+1)  number of stored words, 0..DEPTH.
REQ-014 empty  output  1  level==0.
REQ-015 full  output  1  level==DEPTH.
REQ-016 credits  output  $clog2(DEPTH+1)  free slots, DEPTH-level.

Function
REQ-017 Push = s_valid&&s_ready at a rising edge; pop = m_valid&&m_ready at a rising edge.
REQ-018 s_ready SHALL equal !full; m_valid SHALL equal !empty.
REQ-019 Words SHALL leave in strict push order, bit-exact; no word lost, duplicated or reordered.
REQ-020 level after edge: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-021 level, empty, full, credits SHALL be registered or derived only from registered state, consistent in every cycle.
REQ-022 Storage: circular buffer with write/read pointers wrapping from DEPTH-1 to 0; pointer wrap SHALL NOT disturb ordering or level.
REQ-023 Latency: a word pushed into an empty FIFO at edge N SHALL have m_valid=1 and be on m_data immediately after edge N, for both PIPE_OUT values.
REQ-024 PIPE_OUT=0: m_data is combinational read of the entry at the read pointer.
REQ-025 PIPE_OUT=1: m_data/m_valid come from a one-word output register that counts as one of the DEPTH slots; the register reloads from storage (or directly from s_data when storage is empty) on pop or when empty; port behaviour otherwise identical to PIPE_OUT=0.
REQ-026 SKID_EN=1: s_ready is a flop loaded each edge with (next level < DEPTH); port-level behaviour identical to SKID_EN=0.
REQ-027 When full, s_valid is ignored (s_ready=0) even if m_ready=1; only the pop occurs, level becomes DEPTH-1.
REQ-028 When empty, m_ready is ignored (m_valid=0); m_data is don't-care.
REQ-029 Simultaneous push+pop at 0<level<DEPTH SHALL transfer both words in the same edge.
REQ-030 s_data is sampled only on push; m_data SHALL hold stable while m_valid=1 and m_ready=0.

Reset
REQ-031 While rst_n=1 at an edge: level=0, empty=1, full=0, credits=DEPTH, m_valid=0, s_ready=1 after that edge, pointers=0; storage contents not cleared.
REQ-032 Reset asserted mid-operation SHALL discard all stored words; any push/pop in that cycle is ignored.
REQ-033 First cycle after reset release SHALL accept a push.

Verification
REQ-034 Reset 2 cycles, release -> level=0 empty=1 full=0 credits=8 s_ready=1 m_valid=0.
REQ-035 Push 0xA5A50001 (m_ready=0) -> next cycle m_valid=1 m_data=0xA5A50001 level=1 credits=7; then m_ready=1 -> popped 0xA5A50001, empty=1.
REQ-036 Push 0xA5A50000..0xA5A50007 with m_ready=0 -> full=1 level=8 credits=0 s_ready=0; extra s_valid ignored; drain 8 -> words in order, empty=1.
REQ-037 Fill to level 6 (0xA5A51000..05), then s_valid=1 s_data=0xA5A52000 m_ready=1 one edge -> popped 0xA5A51000, level stays 6; mid-operation reset -> level=0 empty=1.
REQ-038 1500 cycles random s_valid/m_ready/s_data with scoreboard -> no pop without expected word, every popped word matches; coverage hits full, empty, push+pop, every level 1..7, backpressure (m_valid&&!m_ready).
REQ-039 Repeat REQ-035..038 for each combination of PIPE_OUT and SKID_EN -> identical port-level results.
